// File: rtl/vl_strip_ctrl.sv
// vl_strip_ctrl: accepts one vector configuration, computes VLMAX once and
// strip-mines the AVL into a valid/ready stream of per-strip vl values.
module vl_strip_ctrl #(
  parameter  int VLEN         = 64,
  parameter  int AVL_W        = 9,
  parameter  int MAX_LMUL_ENC = 4,
  localparam int VL_W         = $clog2(4*VLEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [2:0]       sew_enc_i,
  input  logic [2:0]       lmul_enc_i,
  input  logic [AVL_W-1:0] avl_i,
  input  logic             flush_i,
  output logic             strip_valid_o,
  input  logic             strip_ready_i,
  output logic [VL_W-1:0]  strip_vl_o,
  output logic             strip_last_o,
  output logic [7:0]       strip_idx_o,
  output logic [VL_W-1:0]  vlmax_o,
  output logic             vill_o,
  output logic             busy_o
);

  // remaining must hold the full AVL even if AVL_W exceeds VL_W
  localparam int REM_W = (AVL_W > VL_W) ? AVL_W : VL_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_STRIP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       sew_q, sew_d, lmul_q, lmul_d;
  logic [REM_W-1:0] rem_q, rem_d, rem_after_s;
  logic             strip_valid_q, strip_valid_d, strip_last_q, strip_last_d;
  logic [VL_W-1:0]  strip_vl_q, strip_vl_d, vlmax_q, vlmax_d, vlmax_calc_s;
  logic [7:0]       idx_q, idx_d;
  logic             vill_q, vill_d, busy_q, busy_d, cfg_ready_q, cfg_ready_d;
  logic             legal_s;

  function automatic logic [VL_W-1:0] clip_vl(input logic [REM_W-1:0] rem,
                                               input logic [VL_W-1:0]  vmax);
    logic [VL_W-1:0] res;
    if (rem <= REM_W'(vmax)) res = VL_W'(rem);
    else                     res = vmax;
    return res;
  endfunction

  function automatic logic is_last(input logic [REM_W-1:0] rem,
                                   input logic [VL_W-1:0]  vmax);
    return (rem <= REM_W'(vmax));
  endfunction

  always_comb begin
    legal_s      = (sew_q <= 3'd4) && (lmul_q <= 3'(MAX_LMUL_ENC)) &&
                   (32'(VLEN) >= (32'd4 << sew_q));
    vlmax_calc_s = VL_W'((32'(VLEN) >> ({2'b00, sew_q} + 5'd2)) << lmul_q);
    rem_after_s  = rem_q - REM_W'(strip_vl_q);
  end

  always_comb begin
    state_d       = state_q;
    sew_d         = sew_q;
    lmul_d        = lmul_q;
    rem_d         = rem_q;
    strip_valid_d = strip_valid_q;
    strip_vl_d    = strip_vl_q;
    strip_last_d  = strip_last_q;
    idx_d         = idx_q;
    vlmax_d       = vlmax_q;
    vill_d        = vill_q;
    busy_d        = busy_q;
    cfg_ready_d   = cfg_ready_q;

    // flush wins over both a config offer and a strip handshake
    if (flush_i) begin
      state_d       = S_IDLE;
      strip_valid_d = 1'b0;
      rem_d         = '0;
      busy_d        = 1'b0;
      cfg_ready_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_valid_i) begin
            sew_d       = sew_enc_i;
            lmul_d      = lmul_enc_i;
            rem_d       = REM_W'(avl_i);
            idx_d       = 8'd0;
            state_d     = S_CALC;
            busy_d      = 1'b1;
            cfg_ready_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          if (legal_s) begin
            vlmax_d      = vlmax_calc_s;
            vill_d       = 1'b0;
            strip_vl_d   = clip_vl(rem_q, vlmax_calc_s);
            strip_last_d = is_last(rem_q, vlmax_calc_s);
          end else begin
            vlmax_d      = '0;
            vill_d       = 1'b1;
            rem_d        = '0;
            strip_vl_d   = '0;
            strip_last_d = 1'b1;
          end
          strip_valid_d = 1'b1;
          state_d       = S_STRIP;
        end
        S_STRIP: begin
          if (strip_ready_i) begin
            rem_d = rem_after_s;
            idx_d = idx_q + 8'd1;
            if (strip_last_q) begin
              state_d       = S_IDLE;
              strip_valid_d = 1'b0;
              busy_d        = 1'b0;
              cfg_ready_d   = 1'b1;
            end else begin
              strip_vl_d   = clip_vl(rem_after_s, vlmax_q);
              strip_last_d = is_last(rem_after_s, vlmax_q);
            end
          end else begin
            state_d = S_STRIP;
          end
        end
        default: begin
          state_d       = S_IDLE;
          strip_valid_d = 1'b0;
          busy_d        = 1'b0;
          cfg_ready_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sew_q         <= 3'd0;
      lmul_q        <= 3'd0;
      rem_q         <= '0;
      strip_valid_q <= 1'b0;
      strip_vl_q    <= '0;
      strip_last_q  <= 1'b0;
      idx_q         <= 8'd0;
      vlmax_q       <= '0;
      vill_q        <= 1'b0;
      busy_q        <= 1'b0;
      cfg_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      sew_q         <= sew_d;
      lmul_q        <= lmul_d;
      rem_q         <= rem_d;
      strip_valid_q <= strip_valid_d;
      strip_vl_q    <= strip_vl_d;
      strip_last_q  <= strip_last_d;
      idx_q         <= idx_d;
      vlmax_q       <= vlmax_d;
      vill_q        <= vill_d;
      busy_q        <= busy_d;
      cfg_ready_q   <= cfg_ready_d;
    end
  end

  assign cfg_ready_o   = cfg_ready_q;
  assign strip_valid_o = strip_valid_q;
  assign strip_vl_o    = strip_vl_q;
  assign strip_last_o  = strip_last_q;
  assign strip_idx_o   = idx_q;
  assign vlmax_o       = vlmax_q;
  assign vill_o        = vill_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_vl_strip_ctrl.sv
// tb_vl_strip_ctrl: table-driven and randomized checks of vl_strip_ctrl
// against an arithmetic reference model of VLMAX and strip-mining.
module tb_vl_strip_ctrl;
  localparam int VLEN         = 64;
  localparam int AVL_W        = 9;
  localparam int MAX_LMUL_ENC = 4;
  localparam int VL_W         = $clog2(4*VLEN) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid_i = 1'b0;
  logic             cfg_ready_o;
  logic [2:0]       sew_enc_i = 3'd0;
  logic [2:0]       lmul_enc_i = 3'd0;
  logic [AVL_W-1:0] avl_i = '0;
  logic             flush_i = 1'b0;
  logic             strip_valid_o;
  logic             strip_ready_i = 1'b0;
  logic [VL_W-1:0]  strip_vl_o;
  logic             strip_last_o;
  logic [7:0]       strip_idx_o;
  logic [VL_W-1:0]  vlmax_o;
  logic             vill_o;
  logic             busy_o;

  vl_strip_ctrl #(.VLEN(VLEN), .AVL_W(AVL_W), .MAX_LMUL_ENC(MAX_LMUL_ENC)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .sew_enc_i(sew_enc_i), .lmul_enc_i(lmul_enc_i), .avl_i(avl_i), .flush_i(flush_i),
    .strip_valid_o(strip_valid_o), .strip_ready_i(strip_ready_i), .strip_vl_o(strip_vl_o),
    .strip_last_o(strip_last_o), .strip_idx_o(strip_idx_o), .vlmax_o(vlmax_o),
    .vill_o(vill_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int exp_vl[$];
  bit exp_last[$];
  int exp_vlmax;
  int exp_vill;

  typedef struct {
    int sew; int lmul; int avl; int rdy; int vlmax; int vill;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: VLMAX from element counts, strips by repeated subtraction.
  task automatic model(input int sew, input int lmul, input int avl);
    int sew_bits, rem, vl;
    bit last;
    exp_vl.delete();
    exp_last.delete();
    sew_bits = 4 * (1 << sew);
    if (sew > 4 || lmul > MAX_LMUL_ENC || VLEN < sew_bits) begin
      exp_vill = 1; exp_vlmax = 0; rem = 0;
    end else begin
      exp_vill = 0; exp_vlmax = (VLEN / sew_bits) * (1 << lmul); rem = avl;
    end
    do begin
      vl   = (rem < exp_vlmax) ? rem : exp_vlmax;
      last = (rem <= exp_vlmax);
      exp_vl.push_back(vl);
      exp_last.push_back(last);
      rem -= vl;
    end while (!last);
  endtask

  // Called at a negedge in IDLE; returns at the negedge showing the first strip.
  task automatic start_cfg(input int sew, input int lmul, input int avl, input string tag);
    check({tag, ".cfg_ready"}, cfg_ready_o, 1);
    cfg_valid_i = 1'b1;
    sew_enc_i   = 3'(sew);
    lmul_enc_i  = 3'(lmul);
    avl_i       = AVL_W'(avl);
    @(negedge clk);
    cfg_valid_i = 1'b0;
    check({tag, ".calc_valid"}, strip_valid_o, 0);
    check({tag, ".calc_busy"}, busy_o, 1);
    check({tag, ".calc_ready"}, cfg_ready_o, 0);
    @(negedge clk);
    check({tag, ".vlmax"}, vlmax_o, exp_vlmax);
    check({tag, ".vill"}, vill_o, exp_vill);
  endtask

  task automatic stream(input int k0, input int ready_pct, input string tag);
    int k = k0;
    int budget = 0;
    bit rdy;
    while (k < exp_vl.size() && budget < 4000) begin
      check($sformatf("%s.valid[%0d]", tag, k), strip_valid_o, 1);
      check($sformatf("%s.vl[%0d]", tag, k), strip_vl_o, exp_vl[k]);
      check($sformatf("%s.last[%0d]", tag, k), strip_last_o, exp_last[k]);
      check($sformatf("%s.idx[%0d]", tag, k), strip_idx_o, k % 256);
      rdy = ($urandom_range(99) < ready_pct);
      strip_ready_i = rdy;
      @(negedge clk);
      if (rdy) k++;
      budget++;
    end
    strip_ready_i = 1'b0;
    if (k < exp_vl.size()) check({tag, ".timeout"}, k, exp_vl.size());
    check({tag, ".end_valid"}, strip_valid_o, 0);
    check({tag, ".end_ready"}, cfg_ready_o, 1);
    check({tag, ".end_busy"}, busy_o, 0);
    check({tag, ".end_vlmax"}, vlmax_o, exp_vlmax);
    check({tag, ".end_vill"}, vill_o, exp_vill);
  endtask

  task automatic run_cfg(input int sew, input int lmul, input int avl, input int rdy, input string tag);
    model(sew, lmul, avl);
    start_cfg(sew, lmul, avl, tag);
    stream(0, rdy, tag);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".valid"}, strip_valid_o, 0);
    check({tag, ".vl"}, strip_vl_o, 0);
    check({tag, ".last"}, strip_last_o, 0);
    check({tag, ".idx"}, strip_idx_o, 0);
    check({tag, ".vlmax"}, vlmax_o, 0);
    check({tag, ".vill"}, vill_o, 0);
    check({tag, ".busy"}, busy_o, 0);
    check({tag, ".cfg_ready"}, cfg_ready_o, 1);
  endtask

  initial begin
    vecs[0] = '{1, 1,  40, 100,  16, 0};
    vecs[1] = '{0, 4, 511, 100, 256, 0};
    vecs[2] = '{3, 0,   0, 100,   2, 0};
    vecs[3] = '{5, 0,  10, 100,   0, 1};
    vecs[4] = '{3, 0,   5, 100,   2, 0};
    vecs[5] = '{2, 5,  20,  60,   0, 1};
    vecs[6] = '{4, 2,   9,  50,   4, 0};
    vecs[7] = '{1, 3, 100,  70,  64, 0};

    repeat (2) @(negedge clk);
    check_reset_vals("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_rel");

    for (int i = 0; i < 8; i++) begin
      model(vecs[i].sew, vecs[i].lmul, vecs[i].avl);
      start_cfg(vecs[i].sew, vecs[i].lmul, vecs[i].avl, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_vlmax", i), vlmax_o, vecs[i].vlmax);
      check($sformatf("vec%0d.tbl_vill", i), vill_o, vecs[i].vill);
      stream(0, vecs[i].rdy, $sformatf("vec%0d", i));
    end

    // backpressure on strip 1 holds its outputs
    model(1, 1, 40);
    start_cfg(1, 1, 40, "bp");
    strip_ready_i = 1'b1;
    @(negedge clk);
    strip_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("bp.hold_valid", strip_valid_o, 1);
      check("bp.hold_vl", strip_vl_o, 16);
      check("bp.hold_idx", strip_idx_o, 1);
      check("bp.hold_last", strip_last_o, 0);
      @(negedge clk);
    end
    stream(1, 100, "bp");

    // flush beats a simultaneous handshake
    model(1, 1, 40);
    start_cfg(1, 1, 40, "fl");
    strip_ready_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    strip_ready_i = 1'b0;
    check("fl.valid", strip_valid_o, 0);
    check("fl.cfg_ready", cfg_ready_o, 1);
    check("fl.busy", busy_o, 0);
    check("fl.idx", strip_idx_o, 1);
    check("fl.vlmax", vlmax_o, 16);
    check("fl.vill", vill_o, 0);
    flush_i = 1'b1;
    cfg_valid_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    cfg_valid_i = 1'b0;
    check("fl_idle.busy", busy_o, 0);
    check("fl_idle.cfg_ready", cfg_ready_o, 1);
    @(negedge clk);
    check("fl_idle.busy2", busy_o, 0);
    run_cfg(3, 1, 10, 100, "after_fl");

    // asynchronous reset mid-stream
    model(2, 0, 30);
    start_cfg(2, 0, 30, "ar");
    strip_ready_i = 1'b1;
    @(negedge clk);
    strip_ready_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("ar_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("ar_rel");
    run_cfg(2, 0, 30, 100, "after_ar");

    for (int r = 0; r < 20; r++) begin
      run_cfg($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 511),
              $urandom_range(30, 100), $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
